// File: rtl/set_pkg.sv
// Shared types for the circle-set host: mode encodings, controller states
// and the queued job record.
package set_pkg;

  localparam logic [1:0] MODE_A       = 2'd0;
  localparam logic [1:0] MODE_AND     = 2'd1;
  localparam logic [1:0] MODE_XOR     = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  // Tag storage is sized for the widest supported tag; the host uses the low TAG_W bits.
  localparam int TAG_MAX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESULT
  } state_t;

  typedef struct packed {
    logic [23:0]          central;
    logic [11:0]          radius;
    logic [1:0]           mode;
    logic [TAG_MAX_W-1:0] tag;
  } job_t;

endpackage

// File: rtl/set_job_fifo.sv
// Small synchronous job queue with show-ahead head, full/empty flags and
// occupancy count.
module set_job_fifo
  import set_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  job_t                   push_data,
  input  logic                   pop,
  output job_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/set_host.sv
// Initiator-side controller: queues circle-set jobs, dispatches them one at a
// time to the counting engine and returns tagged results.
module set_host
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [23:0]            in_central,
  input  logic [11:0]            in_radius,
  input  logic [1:0]             in_mode,
  output logic                   eng_en,
  output logic [23:0]            eng_central,
  output logic [11:0]            eng_radius,
  output logic [1:0]             eng_mode,
  input  logic                   eng_busy,
  input  logic                   eng_valid,
  input  logic [7:0]             eng_candidate,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_candidate,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           next_state;
  job_t             push_job;
  job_t             head;
  job_t             job_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] tag_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             eng_done;
  logic [7:0]       cand_q;
  logic             err_q;
  logic             unused_tag;

  assign push     = in_valid && !full;
  assign in_ready = !full;
  assign push_job = '{central: in_central, radius: in_radius, mode: in_mode,
                      tag: TAG_MAX_W'(tag_cnt)};

  set_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  // tmo_hit marks the last wait cycle a job is allowed before it is aborted.
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign eng_done = eng_valid && !eng_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (!empty && !eng_busy)
                   next_state = (head.mode == MODE_ILLEGAL) ? RESULT : ISSUE;
      ISSUE:     next_state = WAIT_BUSY;
      WAIT_BUSY: if (tmo_hit) next_state = RESULT;
                 else if (eng_busy) next_state = WAIT_DONE;
      WAIT_DONE: if (tmo_hit || eng_done) next_state = RESULT;
      RESULT:    if (out_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == IDLE) && !empty && !eng_busy;
    eng_en    = (state == ISSUE);
    out_valid = (state == RESULT);
  end

  // Job registers drive the engine buses, so they stay stable for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      job_q   <= '0;
      tag_cnt <= '0;
      tmo_cnt <= '0;
      cand_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) tag_cnt <= tag_cnt + 1'b1;
      if (pop) begin
        job_q <= head;
        if (head.mode == MODE_ILLEGAL) begin
          cand_q <= '0;
          err_q  <= 1'b1;
        end
      end
      case (state)
        ISSUE: tmo_cnt <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            cand_q <= '0;
            err_q  <= 1'b1;
          end else if (state == WAIT_DONE && eng_done) begin
            cand_q <= eng_candidate;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_central   = job_q.central;
  assign eng_radius    = job_q.radius;
  assign eng_mode      = job_q.mode;
  assign out_candidate = cand_q;
  assign out_tag       = job_q.tag[TAG_W-1:0];
  assign out_err       = err_q;
  assign unused_tag    = ^job_q.tag;

endmodule

// File: tb/tb_set_host.sv
// Directed bench for set_host with a behavioural circle-set counting engine.
module tb_set_host;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_central = '0;
  logic [11:0] in_radius = '0;
  logic [1:0]  in_mode = '0;
  logic        eng_en;
  logic [23:0] eng_central;
  logic [11:0] eng_radius;
  logic [1:0]  eng_mode;
  logic        eng_busy = 1'b0;
  logic        eng_valid = 1'b0;
  logic [7:0]  eng_candidate = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_candidate;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [2:0]  pending;

  int checks = 0;
  int failures = 0;
  int eng_behave = 0;
  int eng_cnt = 0;
  int en_count = 0;
  logic [7:0] eng_pend = '0;

  set_host dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_central    (in_central),
    .in_radius     (in_radius),
    .in_mode       (in_mode),
    .eng_en        (eng_en),
    .eng_central   (eng_central),
    .eng_radius    (eng_radius),
    .eng_mode      (eng_mode),
    .eng_busy      (eng_busy),
    .eng_valid     (eng_valid),
    .eng_candidate (eng_candidate),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_candidate (out_candidate),
    .out_tag       (out_tag),
    .out_err       (out_err),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  function automatic int count_points(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    int x1 = int'(c[23:20]);
    int y1 = int'(c[19:16]);
    int x2 = int'(c[15:12]);
    int y2 = int'(c[11:8]);
    int r1 = int'(r[11:8]);
    int r2 = int'(r[7:4]);
    int n = 0;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        bit a = ((x - x1) * (x - x1) + (y - y1) * (y - y1)) <= r1 * r1;
        bit b = ((x - x2) * (x - x2) + (y - y2) * (y - y2)) <= r2 * r2;
        case (m)
          2'd0:    n += int'(a);
          2'd1:    n += int'(a && b);
          2'd2:    n += int'(a != b);
          default: ;
        endcase
      end
    end
    return n;
  endfunction

  // Engine model: 0 = normal (busy for a few cycles), 1 = never busy, 2 = stuck busy.
  always @(negedge clk) begin
    if (eng_en) en_count++;
    if (eng_behave == 2) begin
      eng_busy = 1'b1;
    end else if (eng_behave == 1) begin
      eng_busy  = 1'b0;
      eng_valid = 1'b0;
    end else if (eng_en) begin
      eng_busy  = 1'b1;
      eng_valid = 1'b0;
      eng_cnt   = 4;
      eng_pend  = 8'(count_points(eng_central, eng_radius, eng_mode));
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_busy      = 1'b0;
        eng_valid     = 1'b1;
        eng_candidate = eng_pend;
      end else begin
        eng_cnt--;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_mode = '0;
    out_ready = 1'b0;
    eng_behave = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_central = c;
    in_radius = r;
    in_mode = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, input logic [1:0] mode_exp,
                             output bit got, output logic [7:0] cand,
                             output logic [3:0] tag, output logic err,
                             output int cycles, output bit mode_ok);
    bit seen = 1'b0;
    got = 1'b0;
    cycles = 0;
    mode_ok = 1'b1;
    cand = 'x;
    tag = 'x;
    err = 'x;
    while (!got && cycles < budget) begin
      if (eng_en) seen = 1'b1;
      if (seen && eng_mode !== mode_exp) mode_ok = 1'b0;
      if (out_valid) begin
        got = 1'b1;
        cand = out_candidate;
        tag = out_tag;
        err = out_err;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || eng_en !== 1'b0) begin
      failures++; $display("FAIL rst_valid_en got=%0b/%0b exp=0/0", out_valid, eng_en);
    end
    checks++;
    if (pending !== 3'd0) begin failures++; $display("FAIL rst_pending got=%0d exp=0", pending); end
    checks++;
    if (out_candidate !== 8'd0 || out_tag !== 4'd0 || out_err !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got=%0d/%0d/%0b exp=0/0/0", out_candidate, out_tag, out_err);
    end
    checks++;
    if (eng_central !== 24'd0 || eng_radius !== 12'd0 || eng_mode !== 2'd0) begin
      failures++; $display("FAIL rst_eng_bus got=%0h/%0h/%0d exp=0/0/0", eng_central, eng_radius, eng_mode);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (eng_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_idle got=%0b/%0b/%0b exp=0/0/1", eng_en, out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc, e0;
    do_reset();
    out_ready = 1'b1;
    e0 = en_count;
    push(24'h444400, 12'h220, 2'd0);
    checks++;
    if (eng_en !== 1'b0 || pending !== 3'd1) begin
      failures++; $display("FAIL single_after_write got en=%0b pending=%0d exp en=0 pending=1", eng_en, pending);
    end
    @(negedge clk);
    checks++;
    if (eng_en !== 1'b1) begin failures++; $display("FAIL single_en_latency got=%0b exp=1", eng_en); end
    wait_result(40, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd13) begin failures++; $display("FAIL single_cand got=%0d exp=13", c); end
    checks++;
    if (t !== 4'd0 || e !== 1'b0) begin failures++; $display("FAIL single_tag_err got=%0d/%0b exp=0/0", t, e); end
    checks++;
    if (en_count - e0 != 1) begin failures++; $display("FAIL single_en_pulses got=%0d exp=1", en_count - e0); end
    checks++;
    if (!mok) begin failures++; $display("FAIL single_mode_stable got=0 exp=1"); end
  endtask

  task automatic test_and_xor();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc;
    do_reset();
    out_ready = 1'b1;
    push(24'h444400, 12'h220, 2'd1);
    wait_result(40, 2'd1, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd13 || t !== 4'd0 || e !== 1'b0 || !mok) begin
      failures++; $display("FAIL and_result got=%0d/%0d/%0b/%0b exp=13/0/0/1", c, t, e, mok);
    end
    @(negedge clk);
    push(24'h444400, 12'h220, 2'd2);
    wait_result(40, 2'd2, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd0 || t !== 4'd1 || e !== 1'b0 || !mok) begin
      failures++; $display("FAIL xor_result got=%0d/%0d/%0b/%0b exp=0/1/0/1", c, t, e, mok);
    end
  endtask

  task automatic test_illegal();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc, e0;
    do_reset();
    out_ready = 1'b1;
    e0 = en_count;
    push(24'h444400, 12'h220, 2'd3);
    wait_result(20, 2'd3, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd0 || e !== 1'b1 || t !== 4'd0) begin
      failures++; $display("FAIL illegal_result got=%0d/%0b/%0d exp=0/1/0", c, e, t);
    end
    checks++;
    if (en_count != e0) begin failures++; $display("FAIL illegal_no_en got=%0d exp=0", en_count - e0); end
    @(negedge clk);
    push(24'h444400, 12'h300, 2'd0);
    wait_result(40, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd29 || e !== 1'b0 || t !== 4'd1) begin
      failures++; $display("FAIL illegal_next_job got=%0d/%0b/%0d exp=29/0/1", c, e, t);
    end
    checks++;
    if (en_count - e0 != 1) begin failures++; $display("FAIL illegal_next_en got=%0d exp=1", en_count - e0); end
  endtask

  task automatic test_back_to_back();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc;
    do_reset();
    out_ready = 1'b1;
    push(24'h444400, 12'h220, 2'd0);
    push(24'h444400, 12'h100, 2'd0);
    wait_result(40, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd13 || t !== 4'd0) begin failures++; $display("FAIL b2b_first got=%0d/%0d exp=13/0", c, t); end
    @(negedge clk);
    checks++;
    if (eng_en !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%0b exp=0", eng_en); end
    @(negedge clk);
    checks++;
    if (eng_en !== 1'b1) begin failures++; $display("FAIL b2b_en_after_result got=%0b exp=1", eng_en); end
    wait_result(40, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd5 || t !== 4'd1 || e !== 1'b0) begin
      failures++; $display("FAIL b2b_second got=%0d/%0d/%0b exp=5/1/0", c, t, e);
    end
  endtask

  task automatic test_fill();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc;
    int exp_c [4];
    logic [11:0] rad [4];
    exp_c = '{5, 13, 29, 1};
    rad = '{12'h100, 12'h220, 12'h300, 12'h000};
    do_reset();
    eng_behave = 2;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(24'h444400, rad[i], 2'd0);
    checks++;
    if (pending !== 3'd4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got pending=%0d in_ready=%0b exp 4/0", pending, in_ready);
    end
    in_valid = 1'b1;
    in_radius = 12'h200;
    repeat (3) @(negedge clk);
    checks++;
    if (pending !== 3'd4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_stall got pending=%0d in_ready=%0b exp 4/0", pending, in_ready);
    end
    in_valid = 1'b0;
    eng_behave = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_result(60, 2'd0, got, c, t, e, cyc, mok);
      checks++;
      if (!got || c !== 8'(exp_c[i]) || t !== 4'(i) || e !== 1'b0 || !mok) begin
        failures++; $display("FAIL fill_drain%0d got=%0d/%0d/%0b exp=%0d/%0d/0", i, c, t, e, exp_c[i], i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc, e0;
    do_reset();
    out_ready = 1'b1;
    eng_behave = 1;
    e0 = en_count;
    push(24'h444400, 12'h220, 2'd0);
    @(negedge clk);
    checks++;
    if (eng_en !== 1'b1) begin failures++; $display("FAIL tmo_issue got=%0b exp=1", eng_en); end
    wait_result(150, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || e !== 1'b1 || c !== 8'd0 || t !== 4'd0) begin
      failures++; $display("FAIL tmo_result got=%0d/%0b/%0d exp=0/1/0", c, e, t);
    end
    checks++;
    if (cyc != 97) begin failures++; $display("FAIL tmo_cycles got=%0d exp=97", cyc); end
    @(negedge clk);
    eng_behave = 2;
    push(24'h444400, 12'h220, 2'd0);
    repeat (6) @(negedge clk);
    checks++;
    if (pending !== 3'd1 || en_count - e0 != 1) begin
      failures++; $display("FAIL tmo_gate got pending=%0d en=%0d exp 1/1", pending, en_count - e0);
    end
    eng_behave = 0;
    wait_result(60, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd13 || e !== 1'b0 || t !== 4'd1) begin
      failures++; $display("FAIL tmo_recover got=%0d/%0b/%0d exp=13/0/1", c, e, t);
    end
  endtask

  task automatic test_reset_mid_job();
    bit got, mok;
    logic [7:0] c;
    logic [3:0] t;
    logic e;
    int cyc, e0;
    do_reset();
    out_ready = 1'b1;
    push(24'h444400, 12'h220, 2'd1);
    push(24'h444400, 12'h100, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || eng_en !== 1'b0 || pending !== 3'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_outputs got=%0b/%0b/%0d/%0b exp=0/0/0/1", out_valid, eng_en, pending, in_ready);
    end
    checks++;
    if (eng_mode !== 2'd0 || eng_central !== 24'd0 || out_tag !== 4'd0) begin
      failures++; $display("FAIL midrst_bus got=%0d/%0h/%0d exp=0/0/0", eng_mode, eng_central, out_tag);
    end
    e0 = en_count;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (en_count != e0 || out_valid !== 1'b0 || pending !== 3'd0) begin
      failures++; $display("FAIL midrst_quiet got en=%0d valid=%0b pending=%0d exp 0/0/0", en_count - e0, out_valid, pending);
    end
    push(24'h444400, 12'h300, 2'd0);
    wait_result(40, 2'd0, got, c, t, e, cyc, mok);
    checks++;
    if (!got || c !== 8'd29 || t !== 4'd0 || e !== 1'b0) begin
      failures++; $display("FAIL midrst_restart got=%0d/%0d/%0b exp=29/0/0", c, t, e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_and_xor();
    test_illegal();
    test_back_to_back();
    test_fill();
    test_timeout();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
